// File: rtl/mrd_rdx_gather.sv
// mrd_rdx_gather
// Collects a serial stream of complex samples into parallel groups of `factor`
// lanes, so a mixed-radix butterfly can consume one group per beat. The radix
// (`factor`) and block exponent (`in_exp`) are captured at start-of-frame and
// are carried alongside every group of that frame.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         serial input handshake (accept = valid & ready)
//   in_sop, in_eop            frame delimiters on the input stream
//   in_real, in_imag          signed sample, DW bits per component
//   in_exp, factor            frame block exponent / radix, sampled at sop
//   out_valid/out_ready       group output handshake
//   out_sop, out_eop          first / last group of a frame
//   out_real, out_imag        lane k at bits [k*DW +: DW]; unused lanes are zero
//   out_exp, out_factor       frame values travelling with the group
//   err_factor                illegal radix seen at sop (frame dropped)
//   err_short                 frame ended on a partial group (zero-padded)
//   err_sop                   new sop arrived while a group was half-gathered
module mrd_rdx_gather #(
  parameter int DW      = 18,
  parameter int MAX_RDX = 5,
  parameter int EXPW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic signed [DW-1:0]   in_real,
  input  logic signed [DW-1:0]   in_imag,
  input  logic [EXPW-1:0]        in_exp,
  input  logic [2:0]             factor,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [MAX_RDX*DW-1:0]  out_real,
  output logic [MAX_RDX*DW-1:0]  out_imag,
  output logic [EXPW-1:0]        out_exp,
  output logic [2:0]             out_factor,
  input  logic                   out_ready,
  output logic                   err_factor,
  output logic                   err_short,
  output logic                   err_sop
);

  typedef enum logic [1:0] {IDLE, GATHER, DROP} state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [2:0]        cur_factor;
  logic [EXPW-1:0]   cur_exp;
  logic              first_grp;

  logic [DW-1:0]     lane_re [MAX_RDX];
  logic [DW-1:0]     lane_im [MAX_RDX];

  logic              accept;
  logic              factor_ok;
  logic              gather_beat;
  logic [2:0]        eff_idx;
  logic [2:0]        eff_factor;
  logic [EXPW-1:0]   eff_exp;
  logic              eff_first;
  logic              last_lane;
  logic              emit;
  logic [MAX_RDX*DW-1:0] grp_re;
  logic [MAX_RDX*DW-1:0] grp_im;

  // Single output register: a new group may load in the same cycle the held
  // one is consumed, so continuous flow has no bubble.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign factor_ok = (factor >= 3'd2) && (int'(factor) <= MAX_RDX);

  // A legal sop beat is itself lane 0 of a fresh frame, so it is handled as a
  // gather beat using the incoming frame parameters instead of the held ones.
  assign eff_idx     = in_sop ? 3'd0    : idx;
  assign eff_factor  = in_sop ? factor  : cur_factor;
  assign eff_exp     = in_sop ? in_exp  : cur_exp;
  assign eff_first   = in_sop ? 1'b1    : first_grp;
  assign gather_beat = accept && (in_sop ? factor_ok : (state == GATHER));
  assign last_lane   = (eff_idx == eff_factor - 3'd1);
  assign emit        = gather_beat && (last_lane || in_eop);

  // Group as it would look if emitted on this beat: stored lanes below idx,
  // the incoming sample at idx, zero above.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    grp_re = '0;
    grp_im = '0;
    for (int k = 0; k < MAX_RDX; k++) begin
      if (3'(k) < eff_idx) begin
        grp_re[k*DW +: DW] = lane_re[k];
        grp_im[k*DW +: DW] = lane_im[k];
      end else if (3'(k) == eff_idx) begin
        grp_re[k*DW +: DW] = in_real;
        grp_im[k*DW +: DW] = in_imag;
      end
    end
  end

  // NOTE: the lane buffer is deliberately not reset: only lanes below idx are
  // ever read, and those are always written earlier in the same frame.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_RDX; k++) begin
      if (gather_beat && (3'(k) == eff_idx)) begin
        lane_re[k] <= in_real;
        lane_im[k] <= in_imag;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cur_factor <= '0;
      cur_exp    <= '0;
      first_grp  <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_exp    <= '0;
      out_factor <= '0;
      err_factor <= 1'b0;
      err_short  <= 1'b0;
      err_sop    <= 1'b0;
    end else begin
      err_factor <= 1'b0;
      err_short  <= 1'b0;
      err_sop    <= 1'b0;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (in_sop) begin
          if (state == GATHER && idx != 3'd0) err_sop <= 1'b1;
          if (!factor_ok) begin
            err_factor <= 1'b1;
            idx        <= '0;
            state      <= in_eop ? IDLE : DROP;
          end else begin
            cur_factor <= factor;
            cur_exp    <= in_exp;
          end
        end

        if (gather_beat) begin
          if (emit) begin
            out_valid  <= 1'b1;
            out_real   <= grp_re;
            out_imag   <= grp_im;
            out_sop    <= eff_first;
            out_eop    <= in_eop;
            out_exp    <= eff_exp;
            out_factor <= eff_factor;
            err_short  <= !last_lane;
            idx        <= '0;
            first_grp  <= 1'b0;
            state      <= in_eop ? IDLE : GATHER;
          end else begin
            idx        <= eff_idx + 3'd1;
            first_grp  <= eff_first;
            state      <= GATHER;
          end
        end else if (!in_sop && state == DROP && in_eop) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mrd_rdx_gather.sv
// Bench for mrd_rdx_gather: directed frames, a queue-based frame model that
// predicts every group and error pulse, and literal expectations per scenario.
module tb_mrd_rdx_gather;
  localparam int DW      = 18;
  localparam int MAX_RDX = 5;
  localparam int EXPW    = 4;
  localparam int W       = MAX_RDX * DW;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sop, in_eop;
  logic signed [DW-1:0] in_real, in_imag;
  logic [EXPW-1:0] in_exp;
  logic [2:0] factor;
  logic in_ready, out_valid, out_sop, out_eop;
  logic [W-1:0] out_real, out_imag;
  logic [EXPW-1:0] out_exp;
  logic [2:0] out_factor;
  logic out_ready;
  logic err_factor, err_short, err_sop;

  always #5 clk = ~clk;

  mrd_rdx_gather #(.DW(DW), .MAX_RDX(MAX_RDX), .EXPW(EXPW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp), .factor(factor),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag),
    .out_exp(out_exp), .out_factor(out_factor), .out_ready(out_ready),
    .err_factor(err_factor), .err_short(err_short), .err_sop(err_sop)
  );

  typedef struct packed {
    logic [W-1:0]    re;
    logic [W-1:0]    im;
    logic            sop;
    logic            eop;
    logic [EXPW-1:0] exp;
    logic [2:0]      fac;
  } grp_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- frame model ----------------
  bit m_active;
  int m_fac;
  logic [EXPW-1:0] m_exp;
  bit m_first;
  logic [DW-1:0] q_re[$];
  logic [DW-1:0] q_im[$];
  grp_t eq[$];
  grp_t log_q[$];
  bit e_fac, e_short, e_sop;
  int cnt_fac = 0, cnt_short = 0, cnt_sop = 0;
  bit acc_seen;
  bit pat_en = 1'b0;
  int pc = 0;
  logic [3:0] pat = 4'b1001;

  task automatic model_reset();
    m_active = 1'b0;
    m_first  = 1'b0;
    q_re.delete();
    q_im.delete();
    eq.delete();
    e_fac = 0; e_short = 0; e_sop = 0;
  endtask

  task automatic model_accept();
    grp_t g;
    if (in_sop) begin
      if (m_active && q_re.size() != 0) e_sop = 1'b1;
      q_re.delete();
      q_im.delete();
      if (int'(factor) < 2 || int'(factor) > MAX_RDX) begin
        e_fac = 1'b1;
        m_active = 1'b0;
        return;
      end
      m_active = 1'b1;
      m_fac    = int'(factor);
      m_exp    = in_exp;
      m_first  = 1'b1;
    end else if (!m_active) begin
      return;
    end
    q_re.push_back(in_real);
    q_im.push_back(in_imag);
    if (q_re.size() == m_fac || in_eop) begin
      g = '0;
      for (int k = 0; k < q_re.size(); k++) begin
        g.re[k*DW +: DW] = q_re[k];
        g.im[k*DW +: DW] = q_im[k];
      end
      g.sop = m_first;
      g.eop = in_eop;
      g.exp = m_exp;
      g.fac = 3'(m_fac);
      if (q_re.size() != m_fac) e_short = 1'b1;
      eq.push_back(g);
      q_re.delete();
      q_im.delete();
      m_first = 1'b0;
      if (in_eop) m_active = 1'b0;
    end
  endtask

  // Runs once per cycle on the falling edge, where inputs and outputs are
  // stable and describe what the next rising edge will do.
  task automatic monitor_step();
    grp_t a;
    acc_seen = in_valid && in_ready;
    if (rst) begin
      model_reset();
      return;
    end
    check("err_factor", err_factor, e_fac);
    check("err_short",  err_short,  e_short);
    check("err_sop",    err_sop,    e_sop);
    if (err_factor) cnt_fac++;
    if (err_short)  cnt_short++;
    if (err_sop)    cnt_sop++;
    e_fac = 0; e_short = 0; e_sop = 0;
    check("out_valid", out_valid, eq.size() != 0);
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && eq.size() != 0) begin
      check("out_real",   out_real,   eq[0].re);
      check("out_imag",   out_imag,   eq[0].im);
      check("out_sop",    out_sop,    eq[0].sop);
      check("out_eop",    out_eop,    eq[0].eop);
      check("out_exp",    out_exp,    eq[0].exp);
      check("out_factor", out_factor, eq[0].fac);
      if (out_ready) begin
        a.re = out_real; a.im = out_imag; a.sop = out_sop; a.eop = out_eop;
        a.exp = out_exp; a.fac = out_factor;
        log_q.push_back(a);
        void'(eq.pop_front());
      end
    end
    if (acc_seen) model_accept();
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
    if (pat_en) begin
      out_ready = pat[pc % 4];
      pc++;
    end
  endtask

  task automatic send(input int v, input bit sop, input bit eop, input int fac, input int exp);
    int n = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_real  = DW'(v);
    in_imag  = DW'(-v);
    factor   = 3'(fac);
    in_exp   = EXPW'(exp);
    do begin
      tick();
      n++;
    end while (!acc_seen && n < 50);
    if (!acc_seen) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [W-1:0] pack5(input int a, b, c, d, e, input bit neg);
    logic [W-1:0] r;
    int vals[5];
    vals = '{a, b, c, d, e};
    r = '0;
    for (int k = 0; k < 5; k++) r[k*DW +: DW] = DW'(neg ? -vals[k] : vals[k]);
    return r;
  endfunction

  function automatic grp_t lg(input int i);
    grp_t g = '0;
    if (i < log_q.size()) g = log_q[i];
    return g;
  endfunction

  int b, bf, bs, bp;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_real = '0; in_imag = '0;
    in_exp = '0; factor = '0; out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_real", out_real, 0);
    check("rst_out_exp", out_exp, 0);
    check("rst_errs", {err_factor, err_short, err_sop}, 0);
    rst = 1'b0;
    idle(2);

    // factor 3, exp 2, six samples
    b = log_q.size(); bf = cnt_fac; bs = cnt_short; bp = cnt_sop;
    for (int i = 1; i <= 6; i++) send(i, i == 1, i == 6, 3, 2);
    idle(4);
    check("f3_groups", log_q.size() - b, 2);
    check("f3_g0_re", lg(b).re, pack5(1, 2, 3, 0, 0, 0));
    check("f3_g0_im", lg(b).im, pack5(1, 2, 3, 0, 0, 1));
    check("f3_g0_sopeop", {lg(b).sop, lg(b).eop}, 2'b10);
    check("f3_g1_re", lg(b+1).re, pack5(4, 5, 6, 0, 0, 0));
    check("f3_g1_sopeop", {lg(b+1).sop, lg(b+1).eop}, 2'b01);
    check("f3_exp", lg(b+1).exp, 2);
    check("f3_no_err", cnt_fac + cnt_short + cnt_sop - bf - bs - bp, 0);

    // factor 5, ten samples with out_ready toggling 1,0,0,1
    b = log_q.size();
    pc = 0;
    pat_en = 1'b1;
    for (int i = 11; i <= 20; i++) send(i, i == 11, i == 20, 5, 7);
    idle(6);
    pat_en = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("f5_groups", log_q.size() - b, 2);
    check("f5_g0_re", lg(b).re, pack5(11, 12, 13, 14, 15, 0));
    check("f5_g1_re", lg(b+1).re, pack5(16, 17, 18, 19, 20, 0));
    check("f5_g1_im", lg(b+1).im, pack5(16, 17, 18, 19, 20, 1));

    // factor 4, frame of 6 -> partial tail
    b = log_q.size(); bs = cnt_short;
    for (int i = 21; i <= 26; i++) send(i, i == 21, i == 26, 4, 1);
    idle(4);
    check("f4_groups", log_q.size() - b, 2);
    check("f4_g0_re", lg(b).re, pack5(21, 22, 23, 24, 0, 0));
    check("f4_g1_re", lg(b+1).re, pack5(25, 26, 0, 0, 0, 0));
    check("f4_g1_eop", lg(b+1).eop, 1);
    check("f4_short", cnt_short - bs, 1);

    // illegal factor 7, then factor 2 frame
    b = log_q.size(); bf = cnt_fac;
    send(31, 1, 0, 7, 3);
    send(32, 0, 0, 7, 3);
    send(41, 1, 0, 2, 5);
    send(42, 0, 1, 2, 5);
    idle(4);
    check("f7_err", cnt_fac - bf, 1);
    check("f7_groups", log_q.size() - b, 1);
    check("f2_re", lg(b).re, pack5(41, 42, 0, 0, 0, 0));
    check("f2_sopeop", {lg(b).sop, lg(b).eop}, 2'b11);
    check("f2_fac", lg(b).fac, 2);

    // sop interrupting a half-gathered group
    b = log_q.size(); bp = cnt_sop;
    send(51, 1, 0, 2, 0);
    send(61, 1, 0, 2, 4);
    send(62, 0, 1, 2, 4);
    idle(4);
    check("sop_err", cnt_sop - bp, 1);
    check("sop_groups", log_q.size() - b, 1);
    check("sop_re", lg(b).re, pack5(61, 62, 0, 0, 0, 0));
    check("sop_exp", lg(b).exp, 4);

    // one-sample frame
    b = log_q.size(); bs = cnt_short;
    send(71, 1, 1, 3, 6);
    idle(4);
    check("one_groups", log_q.size() - b, 1);
    check("one_re", lg(b).re, pack5(71, 0, 0, 0, 0, 0));
    check("one_sopeop", {lg(b).sop, lg(b).eop}, 2'b11);
    check("one_short", cnt_short - bs, 1);

    // reset mid-frame, then a stray non-sop sample
    b = log_q.size();
    send(81, 1, 0, 3, 2);
    send(82, 0, 0, 3, 2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    send(83, 0, 0, 3, 2);
    idle(4);
    check("rst_mid_groups", log_q.size() - b, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_real", out_real, 0);
    check("rst_mid_imag", out_imag, 0);
    check("rst_mid_flags", {out_sop, out_eop, out_exp, out_factor}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
